// File: rtl/vip_pkg.sv
// Shared constants for the VIP downstream stages: RGB565 colours, coordinate
// width and default display geometry.
package vip_pkg;

   localparam int unsigned COORD_W       = 12;
   localparam int unsigned IMG_HDISP_DEF = 1024;
   localparam int unsigned IMG_VDISP_DEF = 768;

   localparam logic [15:0] RGB565_BLACK = 16'h0000;
   localparam logic [15:0] RGB565_RED   = 16'hF800;
   localparam logic [15:0] RGB565_GREEN = 16'h07E0;
   localparam logic [15:0] RGB565_BLUE  = 16'h001F;
   localparam logic [15:0] RGB565_WHITE = 16'hFFFF;

endpackage

// File: rtl/vip_pixel_coord.sv
// Pixel coordinate tracker: col/row counters plus vsync/href edge detection,
// reusable by any stage that needs the position of the current input pixel.
module vip_pixel_coord
   import vip_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               vsync,
   input  logic               href,
   input  logic               clken,
   output logic [COORD_W-1:0] col,
   output logic [COORD_W-1:0] row,
   output logic               vsync_rise_c
);

   localparam logic [COORD_W-1:0] COORD_MAX = '1;

   logic vsync_d;
   logic href_d;
   logic href_fall_c;

   assign vsync_rise_c = vsync & ~vsync_d;
   assign href_fall_c  = href_d & ~href;

   // Edge history and saturating counters; col/row describe the pixel now on the inputs.
   // vsync_d resets high so a reset released mid-frame is not mistaken for a frame start.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vsync_d <= 1'b1;
         href_d  <= 1'b0;
         col     <= '0;
         row     <= '0;
      end else begin
         vsync_d <= vsync;
         href_d  <= href;
         if (href_fall_c)
            col <= '0;
         else if (href && clken && (col != COORD_MAX))
            col <= col + COORD_W'(1);
         if (vsync_rise_c)
            row <= '0;
         else if (href_fall_c && (row != COORD_MAX))
            row <= row + COORD_W'(1);
      end
   end

endmodule

// File: rtl/vip_bbox_overlay.sv
// Bounding-box overlay on an RGB565 stream with a fixed 2-clock latency.
// Optional centre crosshair enabled by defining VIP_BBOX_CROSSHAIR_EN.
module vip_bbox_overlay
   import vip_pkg::*;
#(
   parameter int unsigned IMG_HDISP   = IMG_HDISP_DEF,
   parameter int unsigned IMG_VDISP   = IMG_VDISP_DEF,
   parameter int unsigned BORDER_W    = 2,
   parameter logic [15:0] BOX_COLOR   = RGB565_RED,
   parameter logic [15:0] CROSS_COLOR = RGB565_GREEN
)
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               per_frame_vsync,
   input  logic               per_frame_href,
   input  logic               per_frame_clken,
   input  logic [15:0]        per_img_rgb,
   input  logic [COORD_W-1:0] x_min,
   input  logic [COORD_W-1:0] x_max,
   input  logic [COORD_W-1:0] y_min,
   input  logic [COORD_W-1:0] y_max,
   output logic               post_frame_vsync,
   output logic               post_frame_href,
   output logic               post_frame_clken,
   output logic [15:0]        post_img_rgb
);

   localparam int unsigned      SUM_W = COORD_W + 1;
   localparam logic [SUM_W-1:0] BW    = SUM_W'(BORDER_W);

   // Reject geometry the 12-bit coordinates or the border range cannot express.
   if (BORDER_W < 1 || BORDER_W > 8 || IMG_HDISP > 4096 || IMG_VDISP > 4096 ||
       $bits(CROSS_COLOR) != 16) begin : g_cfg_err
      $error("vip_bbox_overlay: unsupported parameter set");
   end

   logic [COORD_W-1:0] col;
   logic [COORD_W-1:0] row;
   logic               vsync_rise_c;

   vip_pixel_coord u_coord (
      .clk          (clk),
      .rst_n        (rst_n),
      .vsync        (per_frame_vsync),
      .href         (per_frame_href),
      .clken        (per_frame_clken),
      .col          (col),
      .row          (row),
      .vsync_rise_c (vsync_rise_c)
   );

   logic [COORD_W-1:0] xs_min, xs_max, ys_min, ys_max;
   logic               box_valid;

   // Shadow box: bounds frozen for the whole frame at the vsync rising edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         xs_min    <= '0;
         xs_max    <= '0;
         ys_min    <= '0;
         ys_max    <= '0;
         box_valid <= 1'b0;
      end else if (vsync_rise_c) begin
         xs_min    <= x_min;
         xs_max    <= x_max;
         ys_min    <= y_min;
         ys_max    <= y_max;
         box_valid <= (x_min <= x_max) && (y_min <= y_max);
      end
   end

   logic [SUM_W-1:0] col_w, row_w, xmin_w, xmax_w, ymin_w, ymax_w;
   logic             inside_c, edge_c, border_c;

   // Border hit in 13-bit arithmetic so bound+BORDER_W never wraps.
   always_comb begin
      col_w    = {1'b0, col};
      row_w    = {1'b0, row};
      xmin_w   = {1'b0, xs_min};
      xmax_w   = {1'b0, xs_max};
      ymin_w   = {1'b0, ys_min};
      ymax_w   = {1'b0, ys_max};
      inside_c = (col_w >= xmin_w) && (col_w <= xmax_w) &&
                 (row_w >= ymin_w) && (row_w <= ymax_w);
      edge_c   = (col_w < xmin_w + BW) || (col_w + BW > xmax_w) ||
                 (row_w < ymin_w + BW) || (row_w + BW > ymax_w);
      border_c = box_valid && per_frame_href && per_frame_clken && inside_c && edge_c;
   end

`ifdef VIP_BBOX_CROSSHAIR_EN
   logic [COORD_W-1:0] cx, cy;
   logic               latch_d;
   logic               cross_c;
   logic               s1_cross;

   // Box centre, computed one cycle after the shadow bounds are latched.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         latch_d <= 1'b0;
         cx      <= '0;
         cy      <= '0;
      end else begin
         latch_d <= vsync_rise_c;
         if (latch_d) begin
            cx <= COORD_W'((xmin_w + xmax_w) >> 1);
            cy <= COORD_W'((ymin_w + ymax_w) >> 1);
         end
      end
   end

   // Crosshair hit: interior pixels on the centre column or centre row.
   always_comb begin
      cross_c = box_valid && per_frame_href && per_frame_clken && inside_c &&
                ((col == cx) || (row == cy));
   end
`endif

   logic        s1_vsync, s1_href, s1_clken, s1_border;
   logic [15:0] s1_rgb;

   // Stage 1: register the stream together with the compare results.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_vsync  <= 1'b0;
         s1_href   <= 1'b0;
         s1_clken  <= 1'b0;
         s1_rgb    <= '0;
         s1_border <= 1'b0;
`ifdef VIP_BBOX_CROSSHAIR_EN
         s1_cross  <= 1'b0;
`endif
      end else begin
         s1_vsync  <= per_frame_vsync;
         s1_href   <= per_frame_href;
         s1_clken  <= per_frame_clken;
         s1_rgb    <= per_img_rgb;
         s1_border <= border_c;
`ifdef VIP_BBOX_CROSSHAIR_EN
         s1_cross  <= cross_c;
`endif
      end
   end

   logic [15:0] mux_c;

   // Colour select: border over crosshair over input pixel.
   always_comb begin
      mux_c = s1_rgb;
`ifdef VIP_BBOX_CROSSHAIR_EN
      if (s1_cross)
         mux_c = CROSS_COLOR;
`endif
      if (s1_border)
         mux_c = BOX_COLOR;
   end

   // Stage 2: output registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         post_frame_vsync <= 1'b0;
         post_frame_href  <= 1'b0;
         post_frame_clken <= 1'b0;
         post_img_rgb     <= '0;
      end else begin
         post_frame_vsync <= s1_vsync;
         post_frame_href  <= s1_href;
         post_frame_clken <= s1_clken;
         post_img_rgb     <= mux_c;
      end
   end

endmodule

// File: tb/tb_vip_bbox_overlay.sv
// Directed bench for vip_bbox_overlay on a 16x8 frame with a 1-pixel border.
module tb_vip_bbox_overlay;

   localparam logic [15:0] BOX   = 16'hF800;
   localparam logic [15:0] CROSS = 16'h07E0;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        vsync, href, clken;
   logic [15:0] rgb;
   logic [11:0] bx0, bx1, by0, by1;
   logic        pv, ph, pc;
   logic [15:0] prgb;

   int n_vec = 0;
   int n_err = 0;

   // Expected {vsync,href,clken,rgb} for the two inputs still in flight.
   logic [18:0] exp_q [2];
   logic [18:0] msk_q [2];

   // Expected box of the frame being driven.
   int ex0, ex1, ey0, ey1;
   bit evalid;

   always #5 clk = ~clk;

   vip_bbox_overlay #(
      .IMG_HDISP   (16),
      .IMG_VDISP   (8),
      .BORDER_W    (1),
      .BOX_COLOR   (BOX),
      .CROSS_COLOR (CROSS)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .per_frame_vsync  (vsync),
      .per_frame_href   (href),
      .per_frame_clken  (clken),
      .per_img_rgb      (rgb),
      .x_min            (bx0),
      .x_max            (bx1),
      .y_min            (by0),
      .y_max            (by1),
      .post_frame_vsync (pv),
      .post_frame_href  (ph),
      .post_frame_clken (pc),
      .post_img_rgb     (prgb)
   );

   function automatic logic [15:0] model_pix(input int c, input int r, input logic [15:0] din);
      if (evalid && c >= ex0 && c <= ex1 && r >= ey0 && r <= ey1) begin
         if (c == ex0 || c == ex1 || r == ey0 || r == ey1)
            return BOX;
`ifdef VIP_BBOX_CROSSHAIR_EN
         if (c == (ex0 + ex1) / 2 || r == (ey0 + ey1) / 2)
            return CROSS;
`endif
      end
      return din;
   endfunction

   // One clock: check the output due now, then drive the next input.
   task automatic step(input string name, input logic rs, input logic vs, input logic hr,
                       input logic ce, input logic [15:0] din, input logic [15:0] dexp,
                       input bit pix);
      logic [18:0] obs;
      @(posedge clk);
      #1;
      obs = {pv, ph, pc, prgb};
      if (msk_q[1] != '0) begin
         n_vec++;
         if ((obs & msk_q[1]) !== (exp_q[1] & msk_q[1])) begin
            n_err++;
            $display("FAIL %s: out=%h expected=%h mask=%h t=%0t", name, obs, exp_q[1], msk_q[1], $time);
         end
      end
      exp_q[1] = exp_q[0];
      msk_q[1] = msk_q[0];
      rst_n = rs;
      vsync = vs;
      href  = hr;
      clken = ce;
      rgb   = din;
      exp_q[0] = {vs, hr, ce, dexp};
      msk_q[0] = pix ? 19'h7FFFF : 19'h70000;
      if (!rs) begin
         exp_q[0] = '0;
         exp_q[1] = '0;
         msk_q[0] = 19'h7FFFF;
         msk_q[1] = 19'h7FFFF;
      end
   endtask

   // Drive one 16x8 frame; optional bound change at chg_row and 3-cycle reset in rst_row.
   task automatic run_frame(input string name, input logic [15:0] kconst, input bit use_const,
                            input bit toggle, input int chg_row, input int rst_row);
      int c, t;
      logic [15:0] d;
      logic ce, rs;
      for (int i = 0; i < 2; i++) step(name, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0F0F, 16'h0F0F, 1'b0);
      for (int i = 0; i < 2; i++) step(name, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0F0F, 16'h0F0F, 1'b0);
      for (int r = 0; r < 8; r++) begin
         if (r == chg_row) begin
            bx0 = 12'd0; bx1 = 12'd15; by0 = 12'd0; by1 = 12'd7;
         end
         c = 0;
         t = 0;
         while (c < 16) begin
            ce = toggle ? ((t % 2) == 0) : 1'b1;
            rs = !(r == rst_row && t >= 5 && t < 8);
            if (!rs) evalid = 1'b0;
            d = use_const ? kconst : 16'(r * 256 + c * 17 + 4096);
            step(name, rs, 1'b1, 1'b1, ce, d, ce ? model_pix(c, r, d) : d, ce);
            if (ce) c++;
            t++;
         end
         for (int i = 0; i < 4; i++) step(name, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0F0F, 16'h0F0F, 1'b0);
      end
      for (int i = 0; i < 2; i++) step(name, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0F0F, 16'h0F0F, 1'b0);
   endtask

   task automatic set_box(input int x0, input int x1, input int y0, input int y1, input bit v);
      bx0 = 12'(x0); bx1 = 12'(x1); by0 = 12'(y0); by1 = 12'(y1);
      ex0 = x0; ex1 = x1; ey0 = y0; ey1 = y1;
      evalid = v;
   endtask

   task automatic test_reset();
      n_vec++;
      if ({pv, ph, pc, prgb} !== 19'h0) begin
         n_err++;
         $display("FAIL reset_first_edge: out=%h expected=00000", {pv, ph, pc, prgb});
      end
      for (int i = 0; i < 3; i++) step("reset_hold", 1'b0, 1'b1, 1'b1, 1'b1, 16'hFFFF, 16'h0, 1'b1);
      for (int i = 0; i < 3; i++) step("reset_idle", 1'b1, 1'b0, 1'b0, 1'b0, 16'h0F0F, 16'h0F0F, 1'b0);
   endtask

   task automatic test_box();
      set_box(4, 11, 2, 5, 1'b1);
      run_frame("box_basic", 16'h001F, 1'b1, 1'b0, -1, -1);
   endtask

   task automatic test_invalid_box();
      set_box(10, 3, 2, 5, 1'b0);
      run_frame("box_invalid", 16'h0, 1'b0, 1'b0, -1, -1);
   endtask

   task automatic test_midframe_change();
      set_box(4, 11, 2, 5, 1'b1);
      run_frame("bounds_hold", 16'h0, 1'b0, 1'b0, 3, -1);
      set_box(0, 15, 0, 7, 1'b1);
      run_frame("bounds_next", 16'h0, 1'b0, 1'b0, -1, -1);
   endtask

   task automatic test_reset_midframe();
      set_box(4, 11, 2, 5, 1'b1);
      run_frame("reset_mid", 16'h0, 1'b0, 1'b0, -1, 3);
      evalid = 1'b1;
      run_frame("reset_recover", 16'h0, 1'b0, 1'b0, -1, -1);
   endtask

   task automatic test_clken_toggle();
      set_box(4, 11, 2, 5, 1'b1);
      run_frame("clken_toggle", 16'h0, 1'b0, 1'b1, -1, -1);
   endtask

`ifdef VIP_BBOX_CROSSHAIR_EN
   task automatic test_crosshair();
      set_box(4, 11, 2, 6, 1'b1);
      run_frame("crosshair", 16'h001F, 1'b1, 1'b0, -1, -1);
   endtask
`endif

   initial begin
      exp_q[0] = '0; exp_q[1] = '0;
      msk_q[0] = '0; msk_q[1] = '0;
      rst_n = 1'b0;
      vsync = 1'b1; href = 1'b1; clken = 1'b1; rgb = 16'hFFFF;
      bx0 = '0; bx1 = '0; by0 = '0; by1 = '0;
      ex0 = 0; ex1 = 0; ey0 = 0; ey1 = 0; evalid = 1'b0;
      @(posedge clk);
      #1;
      test_reset();
      test_box();
      test_invalid_box();
      test_midframe_change();
      test_reset_midframe();
      test_clken_toggle();
`ifdef VIP_BBOX_CROSSHAIR_EN
      test_crosshair();
`endif
      for (int i = 0; i < 3; i++) step("flush", 1'b1, 1'b0, 1'b0, 1'b0, 16'h0F0F, 16'h0F0F, 1'b0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/vip_bbox_overlay.md
# vip_bbox_overlay

Draws the detected hand's bounding box (and optionally a centre crosshair) onto the live RGB565 video stream. It sits directly downstream of the video image processor. It consumes that block's `x_min`/`x_max`/`y_min`/`y_max` box outputs together with a delay-matched RGB565 pixel stream, and feeds the LCD driver. Sync and enable signals pass through with fixed latency, and pixel data is replaced only on box pixels.

## Interface
Parameters:
- `IMG_HDISP`, 1024, active pixels per line
- `IMG_VDISP`, 768, active lines per frame
- `BORDER_W`, 2, box border thickness in pixels (1..8)
- `BOX_COLOR`, 16'hF800, RGB565 border colour
- `CROSS_COLOR`, 16'h07E0, RGB565 crosshair colour (used only with the macro)

Ports:
- `clk`  in  1  pixel clock; the block's only clock
- `rst_n`  in  1  reset; synchronous, active-low
- `per_frame_vsync`  in  1  frame valid; a rising edge marks frame start
- `per_frame_href`  in  1  line valid
- `per_frame_clken`  in  1  pixel enable
- `per_img_rgb`  in  16  RGB565 input pixel
- `x_min`, `x_max`  in  12  box column bounds, inclusive
- `y_min`, `y_max`  in  12  box row bounds, inclusive
- `post_frame_vsync`  out  1  delayed vsync
- `post_frame_href`  out  1  delayed href
- `post_frame_clken`  out  1  delayed clken
- `post_img_rgb`  out  16  overlaid pixel

## Operation
- **Column counter `col` (12 b).**
  - Increments on each `per_frame_clken` while `per_frame_href` = 1.
  - Clears on the `href` falling edge.
  - Saturates at 4095.
- **Row counter `row` (12 b).**
  - Increments on each `href` falling edge.
  - Clears on the `vsync` rising edge.
  - Saturates at 4095.
- **Edge detection.** Edges are found with a 1-cycle registered copy of `vsync` and `href`.
- **Shadow box.** On the `vsync` rising edge, the block latches the four bounds and sets `box_valid` = (`x_min` <= `x_max`) and (`y_min` <= `y_max`). The box is constant for the whole frame; bound changes mid-frame have no effect until the next frame.
- **Border hit.** A pixel is on the border when all three conditions hold:
  - `xs_min` <= `col` <= `xs_max`;
  - `ys_min` <= `row` <= `ys_max`;
  - (`col` < `xs_min`+`BORDER_W`) or (`col`+`BORDER_W` > `xs_max`) or (`row` < `ys_min`+`BORDER_W`) or (`row`+`BORDER_W` > `ys_max`).
- **Arithmetic.** All sums use 13-bit unsigned arithmetic, so there is no wrap. A box narrower than 2·`BORDER_W` renders fully filled.
- **Output mux.**
  - `box_valid` and hit: `BOX_COLOR`.
  - Otherwise: the input pixel, unchanged.
  - When `clken` = 0, the data still passes through, delayed.
- **Pass-through.** With `box_valid` = 0 the block is a pure 2-cycle delay line.
- **Reset value of state.** Counters = 0, shadow bounds = 0, `box_valid` = 0.

## Timing
- Latency is exactly 2 clocks for vsync, href, clken and rgb; all four stay mutually aligned.
  - Stage 1: register the inputs, `col`/`row`, and compare results.
  - Stage 2: colour mux and output registers.
- Reset values: `post_frame_vsync`, `post_frame_href`, `post_frame_clken` = 0 and `post_img_rgb` = 16'h0000. Outputs take these values on the first clock edge with `rst_n` = 0.
- Reset mid-frame: outputs go to 0 at the next edge. After release, `box_valid` stays 0, giving pass-through output, until the next `vsync` rising edge.
- The first pixel of a line has `col` = 0. The line after the first `href` fall has `row` = 1.
- Simultaneous `vsync` rise and `href` fall: the `row` clear wins.
- No backpressure; the block accepts one pixel per clock.

## Configuration
- Macro: `VIP_BBOX_CROSSHAIR_EN`.
- **Defined.**
  - Stage 1 also computes `cx` = (`xs_min`+`xs_max`)>>1 and `cy` = (`ys_min`+`ys_max`)>>1, registered at frame start one cycle after the latch.
  - Pixels inside the box with `col` == `cx` or `row` == `cy` get `CROSS_COLOR`.
  - Priority: border > crosshair > input.
- **Undefined.** No crosshair logic is synthesised, and `CROSS_COLOR` is unused.
- Latency is 2 clocks in both builds.

## Structure
- Shared package `vip_pkg`:
  - RGB565 colour constants;
  - 12-bit coordinate width constant;
  - default `IMG_HDISP`/`IMG_VDISP`.
- One sub-module, `vip_pixel_coord`: the `col`/`row` counters and href/vsync edge detection. It is reusable by other downstream VIP stages.
- The top level holds the shadow box, the hit compare, and the 2-stage pipeline.

## Test plan
- 16×8 frame, box (4,2)-(11,5), `BORDER_W` = 1, input 16'h001F → rows 2 and 5 cols 4..11 plus cols 4 and 11 rows 2..5 give 16'hF800; all other pixels give 16'h001F; 2-cycle latency.
- `x_min` = 10, `x_max` = 3 → `box_valid` = 0; output equals input delayed 2 clocks for the entire frame.
- Bounds changed to (0,0)-(15,7) mid-frame → current frame keeps the old box; next frame draws a border on the image edges.
- `rst_n` low for 3 cycles mid-line → outputs 0 from the next edge; the remainder of the frame is pass-through; the box is drawn again from the next frame.
- `clken` toggling 1/0 within `href` → `col` advances only on `clken`; border columns stay exact.
- With `VIP_BBOX_CROSSHAIR_EN`, box (4,2)-(11,6), `BORDER_W` = 1 → col 7 and row 4 interior pixels give 16'h07E0; the border stays 16'hF800.
